moore_run_detector: RTL and testbench

MOORE_RUN_DETECTOR -- requirements
Module: moore_run_detector

---
 rtl/moore_run_pkg.sv | 19 +
 rtl/moore_run_chan.sv | 98 +++++++++
 rtl/moore_run_detector.sv | 35 +++
 tb/tb_moore_run_detector.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/moore_run_pkg.sv
// Shared types for the per-channel symbol run detector: FSM states, action codes, action width.
package moore_run_pkg;

  localparam int ACT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DONE  = 2'd2
  } run_state_t;

  typedef enum logic [ACT_W-1:0] {
    HOLD = 2'b00,
    CLR  = 2'b01,
    SET  = 2'b10,
    TGL  = 2'b11
  } run_act_t;

endpackage

// File: rtl/moore_run_chan.sv
// Single-channel idle-run detector; optional saturating fire counter under MOORE_RUN_CNT_EN.
//   state | meaning
//   IDLE  | no code latched since reset
//   ARMED | code latched, counting consecutive valid idle symbols
//   DONE  | action for the latched code executed, waiting for the next code
module moore_run_chan
  import moore_run_pkg::*;
#(
  parameter int SYM_W    = 2,
  parameter int IDLE_RUN = 1,
  parameter logic [ACT_W*(2**SYM_W)-1:0] ACT_MAP = 8'b10_11_01_00
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] sym,
  output logic             yout,
  output logic             fire,
  output logic [7:0]       fire_cnt
);

  localparam logic [7:0] RUN_LAST = 8'(IDLE_RUN - 1);

  run_state_t       state_q, state_d;
  logic [SYM_W-1:0] code_q, code_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             yout_q, yout_d;
  logic             fire_q, fire_d;
  logic [SYM_W:0]   act_idx;
  run_act_t         act;

  assign act_idx = {code_q, 1'b0};
  assign act     = run_act_t'(ACT_MAP[act_idx +: ACT_W]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      code_q  <= '0;
      cnt_q   <= '0;
      yout_q  <= 1'b0;
      fire_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      yout_q  <= yout_d;
      fire_q  <= fire_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    yout_d  = yout_q;
    fire_d  = 1'b0;
    if (in_valid) begin
      if (sym != '0) begin
        code_d  = sym;
        cnt_d   = '0;
        state_d = ARMED;
      end else if (state_q == ARMED) begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_q == RUN_LAST) begin
          state_d = DONE;
          fire_d  = 1'b1;
          case (act)
            CLR:     yout_d = 1'b0;
            SET:     yout_d = 1'b1;
            TGL:     yout_d = ~yout_q;
            default: yout_d = yout_q;
          endcase
        end
      end
    end
  end

  assign yout = yout_q;
  assign fire = fire_q;

`ifdef MOORE_RUN_CNT_EN
  logic [7:0] fcnt_q;

  // Counts on the same edge that registers fire, so fire_cnt and fire update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (fire_d && (fcnt_q != 8'hFF)) begin
      fcnt_q <= fcnt_q + 8'd1;
    end
  end

  assign fire_cnt = fcnt_q;
`else
  assign fire_cnt = '0;
`endif

endmodule

// File: rtl/moore_run_detector.sv
// NCH independent idle-run detector channels; define MOORE_RUN_CNT_EN for per-channel fire counters.
module moore_run_detector
  import moore_run_pkg::*;
#(
  parameter int NCH      = 1,
  parameter int SYM_W    = 2,
  parameter int IDLE_RUN = 1,
  parameter logic [ACT_W*(2**SYM_W)-1:0] ACT_MAP = 8'b10_11_01_00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [NCH*SYM_W-1:0] x,
  output logic [NCH-1:0]     yout,
  output logic [NCH-1:0]     fire,
  output logic [NCH*8-1:0]   fire_cnt
);

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    moore_run_chan #(
      .SYM_W    (SYM_W),
      .IDLE_RUN (IDLE_RUN),
      .ACT_MAP  (ACT_MAP)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .sym      (x[c*SYM_W +: SYM_W]),
      .yout     (yout[c]),
      .fire     (fire[c]),
      .fire_cnt (fire_cnt[c*8 +: 8])
    );
  end

endmodule

// File: tb/tb_moore_run_detector.sv
// Directed bench: table-driven two-channel vectors plus multi-cycle run/gap/reset sequences.
module tb_moore_run_detector;

  logic        clk = 1'b0;
  logic        reset;
  logic        va, vb, vc;
  logic [3:0]  xa;
  logic [1:0]  xb, xc;
  logic [1:0]  ya, fa;
  logic [15:0] fca;
  logic        yb, fb, yc, fc;
  logic [7:0]  fcb, fcc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moore_run_detector #(.NCH(2)) dut_a (
    .clk(clk), .reset(reset), .in_valid(va), .x(xa),
    .yout(ya), .fire(fa), .fire_cnt(fca)
  );

  // code 2 mapped to HOLD here so a HOLD action can be observed
  moore_run_detector #(.NCH(1), .IDLE_RUN(3), .ACT_MAP(8'b10_00_01_00)) dut_b (
    .clk(clk), .reset(reset), .in_valid(vb), .x(xb),
    .yout(yb), .fire(fb), .fire_cnt(fcb)
  );

  moore_run_detector #(.NCH(1), .IDLE_RUN(2)) dut_c (
    .clk(clk), .reset(reset), .in_valid(vc), .x(xc),
    .yout(yc), .fire(fc), .fire_cnt(fcc)
  );

  typedef struct {
    logic       v;
    logic [3:0] x;
    logic [1:0] y;
    logic [1:0] f;
  } vec_t;

  typedef struct {
    logic       vb;
    logic [1:0] xb;
    logic       fb;
    logic       yb;
    logic       vc;
    logic [1:0] xc;
    logic       fc;
    logic       yc;
  } seq_t;

  vec_t tbl[14];
  seq_t sq[13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_sat;
  logic [7:0] exp_small;
  int         fires_seen;

  initial begin
    // x = {ch1, ch0}; expectations are yout/fire after the sampling edge
    tbl[0]  = '{1'b1, 4'b1011, 2'b00, 2'b00};
    tbl[1]  = '{1'b1, 4'b0000, 2'b11, 2'b11};
    tbl[2]  = '{1'b1, 4'b0000, 2'b11, 2'b00};
    tbl[3]  = '{1'b1, 4'b0010, 2'b11, 2'b00};
    tbl[4]  = '{1'b1, 4'b0000, 2'b10, 2'b01};
    tbl[5]  = '{1'b1, 4'b0000, 2'b10, 2'b00};
    tbl[6]  = '{1'b1, 4'b0100, 2'b10, 2'b00};
    tbl[7]  = '{1'b0, 4'b1111, 2'b10, 2'b00};
    tbl[8]  = '{1'b1, 4'b0000, 2'b00, 2'b10};
    tbl[9]  = '{1'b1, 4'b0011, 2'b00, 2'b00};
    tbl[10] = '{1'b1, 4'b0010, 2'b00, 2'b00};
    tbl[11] = '{1'b1, 4'b0000, 2'b01, 2'b01};
    tbl[12] = '{1'b1, 4'b0100, 2'b01, 2'b00};
    tbl[13] = '{1'b1, 4'b0000, 2'b01, 2'b10};

    // dut_b: IDLE_RUN=3 restart then HOLD across a gap; dut_c: IDLE_RUN=2 with a 5-cycle gap
    sq[0]  = '{1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0};
    sq[1]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0};
    sq[2]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    sq[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    sq[4]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    sq[5]  = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    sq[6]  = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
    sq[7]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1};
    sq[8]  = '{1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    sq[9]  = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1};
    sq[10] = '{1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    sq[11] = '{1'b1, 2'd0, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};
    sq[12] = '{1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1};

`ifdef MOORE_RUN_CNT_EN
    exp_sat   = 8'd255;
    exp_small = 8'd3;
`else
    exp_sat   = 8'd0;
    exp_small = 8'd0;
`endif

    reset = 1'b1;
    va = 1'b1; vb = 1'b1; vc = 1'b1;
    xa = 4'b1111; xb = 2'd3; xc = 2'd3;
    tick();
    tick();
    chk("reset_yout_a", ya, 2'b00);
    chk("reset_fire_a", fa, 2'b00);
    chk("reset_fcnt_a", fca, 16'h0);
    chk("reset_yout_b", yb, 1'b0);
    chk("reset_fire_c", fc, 1'b0);

    @(negedge clk);
    reset = 1'b0;
    xa = '0; xb = '0; xc = '0;
    tick();
    chk("idle_fire_a", fa, 2'b00);

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      va = tbl[i].v;
      xa = tbl[i].x;
      tick();
      chk($sformatf("tbl%0d_yout", i), ya, tbl[i].y);
      chk($sformatf("tbl%0d_fire", i), fa, tbl[i].f);
    end
    chk("tbl_fcnt_ch0", fca[7:0], exp_small);
    chk("tbl_fcnt_ch1", fca[15:8], exp_small);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      vb = sq[i].vb; xb = sq[i].xb;
      vc = sq[i].vc; xc = sq[i].xc;
      tick();
      chk($sformatf("seqb%0d_fire", i), fb, sq[i].fb);
      chk($sformatf("seqb%0d_yout", i), yb, sq[i].yb);
      chk($sformatf("seqc%0d_fire", i), fc, sq[i].fc);
      chk($sformatf("seqc%0d_yout", i), yc, sq[i].yc);
    end

    fires_seen = 0;
    va = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      xa = 4'b0011;
      tick();
      @(negedge clk);
      xa = 4'b0000;
      tick();
      if (fa == 2'b01) fires_seen++;
    end
    chk("runs_fire_count", fires_seen, 300);
    chk("runs_fcnt_sat", fca[7:0], exp_sat);
    chk("runs_fcnt_ch1", fca[15:8], exp_small);
    chk("runs_yout", ya, 2'b01);

    @(negedge clk);
    xa = 4'b0011;
    tick();
    @(negedge clk);
    reset = 1'b1;
    xa = 4'b0000;
    tick();
    chk("midrst_fire", fa, 2'b00);
    chk("midrst_yout", ya, 2'b00);
    chk("midrst_fcnt", fca, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("postrst_fire", fa, 2'b00);
    chk("postrst_yout", ya, 2'b00);
    chk("postrst_fcnt", fca, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
